// File: rtl/miner_ctrl_multi_if.sv
// Signal bundle between the miner controller, the SPI byte link and the core array.
interface miner_ctrl_multi_if #(
  parameter int N_CORES   = 4,
  parameter int H_BYTES   = 32,
  parameter int MSG_BYTES = 12,
  parameter int NONCE_W   = 32
);
  logic                       rx_valid;
  logic [7:0]                 rx_data;
  logic [7:0]                 tx_data;
  logic [N_CORES-1:0]         core_en;
  logic                       core_abort;
  logic [8*H_BYTES-1:0]       prev_h;
  logic [8*MSG_BYTES-1:0]     input_m;
  logic [8*H_BYTES-1:0]       prev_blk;
  logic [N_CORES-1:0]         core_done;
  logic [N_CORES-1:0]         core_found;
  logic [N_CORES*NONCE_W-1:0] core_nonce;
  logic [N_CORES*256-1:0]     core_hash;
  logic                       busy;

  // Environment side: the SPI slave and the sha_top core array.
  modport master (
    output rx_valid, rx_data, core_done, core_found, core_nonce, core_hash,
    input  tx_data, core_en, core_abort, prev_h, input_m, prev_blk, busy
  );

  // Controller side.
  modport slave (
    input  rx_valid, rx_data, core_done, core_found, core_nonce, core_hash,
    output tx_data, core_en, core_abort, prev_h, input_m, prev_blk, busy
  );
endinterface

// File: rtl/miner_ctrl_multi.sv
// Byte-stream command/response controller for an N-core SHA-256d miner.
// Loads a work unit from the SPI byte stream, starts all cores together,
// merges their done/found pulses and streams the winning hash and nonce back.
module miner_ctrl_multi #(
  parameter int N_CORES   = 4,
  parameter int H_BYTES   = 32,
  parameter int MSG_BYTES = 12,
  parameter int NONCE_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  miner_ctrl_multi_if.slave bus
);
  localparam int LOAD_BYTES = 2*H_BYTES + MSG_BYTES;
  localparam int SEND_BYTES = 32 + NONCE_W/8;
  // The counter also walks the readout stream, so size it for the longer of the two.
  localparam int CNT_MAX    = (LOAD_BYTES > SEND_BYTES) ? LOAD_BYTES : SEND_BYTES;
  localparam int CNT_W      = $clog2(CNT_MAX + 1);
  localparam int SEND_W     = 256 + NONCE_W;
  localparam int H_W        = 8*H_BYTES;
  localparam int M_W        = 8*MSG_BYTES;

  localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(LOAD_BYTES - 1);
  localparam logic [CNT_W-1:0] M_FIRST   = CNT_W'(H_BYTES);
  localparam logic [CNT_W-1:0] B_FIRST   = CNT_W'(H_BYTES + MSG_BYTES);
  localparam logic [CNT_W-1:0] SEND_END  = CNT_W'(SEND_BYTES);

  localparam logic [7:0] C_WAITING    = 8'hA0;
  localparam logic [7:0] C_WORKING    = 8'hA1;
  localparam logic [7:0] C_MSG_START  = 8'hA2;
  localparam logic [7:0] C_STATUS     = 8'hA3;
  localparam logic [7:0] C_GET_MSG    = 8'hA4;
  localparam logic [7:0] C_DONE       = 8'hA5;
  localparam logic [7:0] C_DONE_FOUND = 8'hA6;
  localparam logic [7:0] C_ABORT      = 8'hA7;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_SEND} state_t;

  state_t             r_state,      w_state_nxt;
  logic [CNT_W-1:0]   r_cnt,        w_cnt_nxt;
  logic [7:0]         r_tx_data,    w_tx_nxt;
  logic [N_CORES-1:0] r_core_en,    w_en_nxt;
  logic               r_core_abort, w_abort_nxt;
  logic [H_W-1:0]     r_prev_h,     w_prev_h_nxt;
  logic [M_W-1:0]     r_input_m,    w_input_m_nxt;
  logic [H_W-1:0]     r_prev_blk,   w_prev_blk_nxt;
  logic [N_CORES-1:0] r_mask,       w_mask_nxt;
  logic               r_res_valid,  w_res_valid_nxt;
  logic [3:0]         r_win_idx,    w_win_idx_nxt;
  logic [NONCE_W-1:0] r_win_nonce,  w_win_nonce_nxt;
  logic [255:0]       r_win_hash,   w_win_hash_nxt;

  logic [N_CORES-1:0] w_found;
  logic [3:0]         w_pick_idx;
  logic [NONCE_W-1:0] w_pick_nonce;
  logic [255:0]       w_pick_hash;
  logic [4:0]         w_pop;
  logic [3:0]         w_done_cnt;
  logic [SEND_W-1:0]  w_send_sh;
  logic [7:0]         w_send_byte;

  // A found flag only counts when it arrives with that core's done pulse.
  assign w_found = bus.core_done & bus.core_found;

  // Lowest-index finder among simultaneous finds, and done-mask popcount.
  always_comb begin
    w_pick_idx   = '0;
    w_pick_nonce = '0;
    w_pick_hash  = '0;
    w_pop        = '0;
    for (int i = N_CORES - 1; i >= 0; i--) begin
      if (w_found[i]) begin
        w_pick_idx   = 4'(i);
        w_pick_nonce = bus.core_nonce[i*NONCE_W +: NONCE_W];
        w_pick_hash  = bus.core_hash[i*256 +: 256];
      end
    end
    for (int i = 0; i < N_CORES; i++) begin
      w_pop = w_pop + {4'b0000, r_mask[i]};
    end
  end

  assign w_done_cnt  = (w_pop > 5'd15) ? 4'd15 : w_pop[3:0];
  // Readout byte r_cnt of {hash, nonce}, most significant byte first.
  assign w_send_sh   = {r_win_hash, r_win_nonce} << {r_cnt, 3'b000};
  assign w_send_byte = w_send_sh[SEND_W-1 -: 8];

  // Next-state and next-register logic for the command FSM.
  always_comb begin
    // NOTE: every target gets a hold/default value first, so no path leaves one unassigned and no latch is inferred.
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_tx_nxt        = r_tx_data;
    w_en_nxt        = '0;
    w_abort_nxt     = 1'b0;
    w_prev_h_nxt    = r_prev_h;
    w_input_m_nxt   = r_input_m;
    w_prev_blk_nxt  = r_prev_blk;
    w_mask_nxt      = r_mask;
    w_res_valid_nxt = r_res_valid;
    w_win_idx_nxt   = r_win_idx;
    w_win_nonce_nxt = r_win_nonce;
    w_win_hash_nxt  = r_win_hash;

    unique case (r_state)
      S_IDLE: begin
        if (bus.rx_valid) begin
          case (bus.rx_data)
            C_MSG_START: begin
              w_state_nxt = S_LOAD;
              w_cnt_nxt   = '0;
            end
            C_GET_MSG: begin
              if (r_res_valid) begin
                w_state_nxt = S_SEND;
                w_cnt_nxt   = '0;
                w_tx_nxt    = {4'h0, r_win_idx};
              end
            end
            C_STATUS: w_tx_nxt = {w_done_cnt, 3'b000, r_res_valid};
            default:  ;
          endcase
        end
      end

      S_LOAD: begin
        if (bus.rx_valid) begin
          if (r_cnt < M_FIRST)      w_prev_h_nxt   = {r_prev_h[H_W-9:0], bus.rx_data};
          else if (r_cnt < B_FIRST) w_input_m_nxt  = {r_input_m[M_W-9:0], bus.rx_data};
          else                      w_prev_blk_nxt = {r_prev_blk[H_W-9:0], bus.rx_data};
          w_cnt_nxt = r_cnt + 1'b1;
          if (r_cnt == LOAD_LAST) begin
            w_state_nxt     = S_RUN;
            w_cnt_nxt       = '0;
            w_en_nxt        = '1;
            w_tx_nxt        = C_WORKING;
            w_mask_nxt      = '0;
            w_res_valid_nxt = 1'b0;
            w_win_idx_nxt   = '0;
            w_win_nonce_nxt = '0;
            w_win_hash_nxt  = '0;
          end
        end
      end

      S_RUN: begin
        if (bus.rx_valid && (bus.rx_data == C_ABORT)) begin
          // Abort takes priority over any done pulse in the same cycle.
          w_state_nxt     = S_IDLE;
          w_cnt_nxt       = '0;
          w_abort_nxt     = 1'b1;
          w_tx_nxt        = C_WAITING;
          w_res_valid_nxt = 1'b0;
        end else begin
          w_mask_nxt = r_mask | bus.core_done;
          if (!r_res_valid && (|w_found)) begin
            w_res_valid_nxt = 1'b1;
            w_win_idx_nxt   = w_pick_idx;
            w_win_nonce_nxt = w_pick_nonce;
            w_win_hash_nxt  = w_pick_hash;
          end
          if (&w_mask_nxt) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_tx_nxt    = w_res_valid_nxt ? C_DONE_FOUND : C_DONE;
          end
        end
      end

      S_SEND: begin
        if (bus.rx_valid) begin
          if (r_cnt == SEND_END) begin
            w_state_nxt     = S_IDLE;
            w_cnt_nxt       = '0;
            w_tx_nxt        = C_WAITING;
            w_res_valid_nxt = 1'b0;
          end else begin
            w_tx_nxt  = w_send_byte;
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and datapath registers; reset returns every output to its idle value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_tx_data    <= C_WAITING;
      r_core_en    <= '0;
      r_core_abort <= 1'b0;
      r_prev_h     <= '0;
      r_input_m    <= '0;
      r_prev_blk   <= '0;
      r_mask       <= '0;
      r_res_valid  <= 1'b0;
      r_win_idx    <= '0;
      r_win_nonce  <= '0;
      r_win_hash   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_tx_data    <= w_tx_nxt;
      r_core_en    <= w_en_nxt;
      r_core_abort <= w_abort_nxt;
      r_prev_h     <= w_prev_h_nxt;
      r_input_m    <= w_input_m_nxt;
      r_prev_blk   <= w_prev_blk_nxt;
      r_mask       <= w_mask_nxt;
      r_res_valid  <= w_res_valid_nxt;
      r_win_idx    <= w_win_idx_nxt;
      r_win_nonce  <= w_win_nonce_nxt;
      r_win_hash   <= w_win_hash_nxt;
    end
  end

  assign bus.tx_data    = r_tx_data;
  assign bus.core_en    = r_core_en;
  assign bus.core_abort = r_core_abort;
  assign bus.prev_h     = r_prev_h;
  assign bus.input_m    = r_input_m;
  assign bus.prev_blk   = r_prev_blk;
  assign bus.busy       = (r_state == S_LOAD) || (r_state == S_RUN);
endmodule

// File: tb/tb_miner_ctrl_multi.sv
// Self-checking bench for miner_ctrl_multi: directed scenarios plus randomized
// work units, checked against a byte-level model of the command protocol.
module tb_miner_ctrl_multi;
  localparam int N_CORES   = 4;
  localparam int H_BYTES   = 32;
  localparam int MSG_BYTES = 12;
  localparam int NONCE_W   = 32;
  localparam int L         = 2*H_BYTES + MSG_BYTES;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_pass  = 0;
  int   n_total = 0;

  // Model state.
  logic [7:0]             work [L];
  logic [255:0]           hsh [N_CORES];
  logic [NONCE_W-1:0]     nnc [N_CORES];
  int                     done_at [N_CORES];
  logic                   fnd [N_CORES];
  logic [8*H_BYTES-1:0]   exp_prev_h, exp_prev_blk;
  logic [8*MSG_BYTES-1:0] exp_input_m;
  logic [7:0]             exp_q [$];

  miner_ctrl_multi_if #(.N_CORES(N_CORES), .H_BYTES(H_BYTES), .MSG_BYTES(MSG_BYTES),
                        .NONCE_W(NONCE_W)) bus ();

  miner_ctrl_multi #(.N_CORES(N_CORES), .H_BYTES(H_BYTES), .MSG_BYTES(MSG_BYTES),
                     .NONCE_W(NONCE_W)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, passed=%0d total=%0d", n_pass, n_total);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  task automatic cycle_cores(input logic [N_CORES-1:0] d, input logic [N_CORES-1:0] f,
                             input logic rx_v, input logic [7:0] rx_b);
    bus.core_done = d; bus.core_found = f; bus.rx_valid = rx_v; bus.rx_data = rx_b;
    @(posedge clk); #1;
    bus.core_done = '0; bus.core_found = '0; bus.rx_valid = 1'b0; bus.rx_data = 8'h00;
  endtask

  task automatic send_byte(input logic [7:0] b);
    cycle_cores('0, '0, 1'b1, b);
  endtask

  task automatic set_cores();
    for (int i = 0; i < N_CORES; i++) begin
      bus.core_nonce[i*NONCE_W +: NONCE_W] = nnc[i];
      bus.core_hash[i*256 +: 256]          = hsh[i];
    end
  endtask

  task automatic rand_cores();
    for (int i = 0; i < N_CORES; i++) begin
      nnc[i] = NONCE_W'($urandom);
      for (int w = 0; w < 8; w++) hsh[i][w*32 +: 32] = $urandom;
    end
    set_cores();
  endtask

  // Expected field contents: byte k of the work unit sits at byte position k from the MSB end.
  task automatic load_work();
    send_byte(8'hA2);
    for (int k = 0; k < L; k++) send_byte(work[k]);
    for (int k = 0; k < H_BYTES; k++) begin
      exp_prev_h[8*(H_BYTES-1-k) +: 8]   = work[k];
      exp_prev_blk[8*(H_BYTES-1-k) +: 8] = work[H_BYTES+MSG_BYTES+k];
    end
    for (int k = 0; k < MSG_BYTES; k++) exp_input_m[8*(MSG_BYTES-1-k) +: 8] = work[H_BYTES+k];
  endtask

  // Winner = earliest cycle carrying a find; within that cycle the lowest index.
  function automatic int model_winner();
    for (int c = 0; c < 16; c++)
      for (int i = 0; i < N_CORES; i++)
        if (done_at[i] == c && fnd[i]) return i;
    return -1;
  endfunction

  // Response stream after GET_MSG: index, hash MSB first, nonce MSB first, then WAITING.
  task automatic build_readout(input int w);
    exp_q = {};
    exp_q.push_back(8'(w));
    for (int k = 0; k < 32; k++) exp_q.push_back(hsh[w][8*(31-k) +: 8]);
    for (int k = 0; k < NONCE_W/8; k++) exp_q.push_back(nnc[w][8*(NONCE_W/8-1-k) +: 8]);
    exp_q.push_back(8'hA0);
  endtask

  task automatic run_cycle(input int c, input logic rx_v, input logic [7:0] rx_b, input logic noise);
    logic [N_CORES-1:0] d, f;
    d = '0; f = '0;
    for (int i = 0; i < N_CORES; i++) begin
      d[i] = (done_at[i] == c);
      f[i] = d[i] ? fnd[i] : (noise ? 1'($urandom) : 1'b0);
    end
    cycle_cores(d, f, rx_v, rx_b);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_total++; if (bus.tx_data !== 8'hA0) $display("FAIL reset_tx got=%h exp=a0", bus.tx_data); else n_pass++;
    n_total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", bus.busy); else n_pass++;
    n_total++; if (bus.core_en !== 4'h0) $display("FAIL reset_core_en got=%h exp=0", bus.core_en); else n_pass++;
    n_total++; if (bus.core_abort !== 1'b0) $display("FAIL reset_abort got=%b exp=0", bus.core_abort); else n_pass++;
    n_total++; if (bus.prev_h !== '0) $display("FAIL reset_prev_h got=%h exp=0", bus.prev_h); else n_pass++;
    reset = 1'b1;
    idle_cycle();
  endtask

  task automatic test_load();
    for (int k = 0; k < L; k++) work[k] = 8'(k);
    send_byte(8'hA2);
    n_total++; if (bus.busy !== 1'b1) $display("FAIL load_busy got=%b exp=1", bus.busy); else n_pass++;
    n_total++; if (bus.tx_data !== 8'hA0) $display("FAIL load_tx_hold got=%h exp=a0", bus.tx_data); else n_pass++;
    for (int k = 0; k < L; k++) begin
      send_byte(work[k]);
      n_total++;
      if (bus.core_en !== ((k == L-1) ? 4'hF : 4'h0))
        $display("FAIL load_core_en byte=%0d got=%h exp=%h", k, bus.core_en, (k == L-1) ? 4'hF : 4'h0);
      else n_pass++;
    end
    for (int k = 0; k < H_BYTES; k++) begin
      exp_prev_h[8*(H_BYTES-1-k) +: 8]   = 8'(k);
      exp_prev_blk[8*(H_BYTES-1-k) +: 8] = 8'(H_BYTES + MSG_BYTES + k);
    end
    for (int k = 0; k < MSG_BYTES; k++) exp_input_m[8*(MSG_BYTES-1-k) +: 8] = 8'(H_BYTES + k);
    n_total++; if (bus.prev_h !== exp_prev_h) $display("FAIL load_prev_h got=%h exp=%h", bus.prev_h, exp_prev_h); else n_pass++;
    n_total++; if (bus.input_m !== exp_input_m) $display("FAIL load_input_m got=%h exp=%h", bus.input_m, exp_input_m); else n_pass++;
    n_total++; if (bus.prev_blk !== exp_prev_blk) $display("FAIL load_prev_blk got=%h exp=%h", bus.prev_blk, exp_prev_blk); else n_pass++;
    n_total++; if (bus.tx_data !== 8'hA1) $display("FAIL load_tx got=%h exp=a1", bus.tx_data); else n_pass++;
    idle_cycle();
    n_total++; if (bus.core_en !== 4'h0) $display("FAIL load_en_pulse got=%h exp=0", bus.core_en); else n_pass++;
    send_byte(8'hA7);
    n_total++; if (bus.tx_data !== 8'hA0) $display("FAIL load_abort_tx got=%h exp=a0", bus.tx_data); else n_pass++;
  endtask

  task automatic test_find();
    rand_cores();
    nnc[1] = 32'hDEADBEEF; nnc[2] = 32'hDEADBEEF;
    set_cores();
    done_at = '{1, 0, 0, 1};
    fnd     = '{1'b0, 1'b1, 1'b1, 1'b0};
    for (int k = 0; k < L; k++) work[k] = 8'($urandom);
    load_work();
    run_cycle(0, 1'b0, 8'h00, 1'b0);
    n_total++; if (bus.tx_data !== 8'hA1) $display("FAIL find_running_tx got=%h exp=a1", bus.tx_data); else n_pass++;
    run_cycle(1, 1'b0, 8'h00, 1'b0);
    n_total++; if (bus.tx_data !== 8'hA6) $display("FAIL find_done_tx got=%h exp=a6", bus.tx_data); else n_pass++;
    n_total++; if (bus.busy !== 1'b0) $display("FAIL find_busy got=%b exp=0", bus.busy); else n_pass++;
    build_readout(model_winner());
    send_byte(8'hA4);
    n_total++; if (bus.tx_data !== exp_q[0]) $display("FAIL find_index got=%h exp=%h", bus.tx_data, exp_q[0]); else n_pass++;
    for (int k = 1; k < exp_q.size(); k++) begin
      send_byte(8'($urandom));
      n_total++;
      if (bus.tx_data !== exp_q[k]) $display("FAIL find_stream byte=%0d got=%h exp=%h", k, bus.tx_data, exp_q[k]);
      else n_pass++;
    end
    send_byte(8'hA4);
    n_total++; if (bus.tx_data !== 8'hA0) $display("FAIL find_reget got=%h exp=a0", bus.tx_data); else n_pass++;
    send_byte(8'hA3);
    n_total++; if (bus.tx_data !== 8'h40) $display("FAIL find_status got=%h exp=40", bus.tx_data); else n_pass++;
  endtask

  task automatic test_no_find();
    rand_cores();
    for (int k = 0; k < L; k++) work[k] = 8'($urandom);
    load_work();
    cycle_cores(4'b0011, 4'b1100, 1'b0, 8'h00);
    n_total++; if (bus.busy !== 1'b1) $display("FAIL nofind_busy got=%b exp=1", bus.busy); else n_pass++;
    cycle_cores(4'b1100, 4'b0000, 1'b0, 8'h00);
    n_total++; if (bus.tx_data !== 8'hA5) $display("FAIL nofind_tx got=%h exp=a5", bus.tx_data); else n_pass++;
    send_byte(8'hA4);
    n_total++; if (bus.tx_data !== 8'hA5) $display("FAIL nofind_get_ignored got=%h exp=a5", bus.tx_data); else n_pass++;
    send_byte(8'h55);
    n_total++; if (bus.tx_data !== 8'hA5) $display("FAIL nofind_other_ignored got=%h exp=a5", bus.tx_data); else n_pass++;
    send_byte(8'hA3);
    n_total++; if (bus.tx_data !== 8'h40) $display("FAIL nofind_status got=%h exp=40", bus.tx_data); else n_pass++;
  endtask

  task automatic test_abort();
    rand_cores();
    for (int k = 0; k < L; k++) work[k] = 8'($urandom);
    load_work();
    cycle_cores(4'b0111, 4'b0001, 1'b0, 8'h00);
    cycle_cores(4'b1000, 4'b0000, 1'b1, 8'hA7);
    n_total++; if (bus.core_abort !== 1'b1) $display("FAIL abort_pulse got=%b exp=1", bus.core_abort); else n_pass++;
    n_total++; if (bus.tx_data !== 8'hA0) $display("FAIL abort_tx got=%h exp=a0", bus.tx_data); else n_pass++;
    n_total++; if (bus.busy !== 1'b0) $display("FAIL abort_busy got=%b exp=0", bus.busy); else n_pass++;
    idle_cycle();
    n_total++; if (bus.core_abort !== 1'b0) $display("FAIL abort_pulse_end got=%b exp=0", bus.core_abort); else n_pass++;
    send_byte(8'hA4);
    n_total++; if (bus.tx_data !== 8'hA0) $display("FAIL abort_result_cleared got=%h exp=a0", bus.tx_data); else n_pass++;
  endtask

  task automatic test_status_reset();
    rand_cores();
    for (int k = 0; k < L; k++) work[k] = 8'($urandom);
    load_work();
    cycle_cores(4'b0001, 4'b0000, 1'b0, 8'h00);
    cycle_cores(4'b0100, 4'b0000, 1'b1, 8'hA3);
    n_total++; if (bus.tx_data !== 8'hA1) $display("FAIL status_in_run_ignored got=%h exp=a1", bus.tx_data); else n_pass++;
    cycle_cores(4'b0010, 4'b0000, 1'b0, 8'h00);
    send_byte(8'hA7);
    send_byte(8'hA3);
    n_total++; if (bus.tx_data !== 8'h30) $display("FAIL status_three got=%h exp=30", bus.tx_data); else n_pass++;
    send_byte(8'hA2);
    for (int k = 0; k < 10; k++) send_byte(8'hFF);
    reset = 1'b0;
    #2;
    n_total++; if (bus.tx_data !== 8'hA0) $display("FAIL midload_reset_tx got=%h exp=a0", bus.tx_data); else n_pass++;
    n_total++; if (bus.busy !== 1'b0) $display("FAIL midload_reset_busy got=%b exp=0", bus.busy); else n_pass++;
    n_total++; if (bus.prev_h !== '0) $display("FAIL midload_reset_prev_h got=%h exp=0", bus.prev_h); else n_pass++;
    repeat (2) @(posedge clk);
    #1;
    n_total++; if (bus.core_en !== 4'h0 || bus.core_abort !== 1'b0)
      $display("FAIL midload_reset_pulses got=%h/%b exp=0/0", bus.core_en, bus.core_abort); else n_pass++;
    reset = 1'b1;
    idle_cycle();
    send_byte(8'hA3);
    n_total++; if (bus.tx_data !== 8'h00) $display("FAIL status_after_reset got=%h exp=00", bus.tx_data); else n_pass++;
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      int last, win;
      logic [7:0] b;
      logic       rv;
      rand_cores();
      for (int k = 0; k < L; k++) work[k] = 8'($urandom);
      last = 0;
      for (int i = 0; i < N_CORES; i++) begin
        done_at[i] = $urandom_range(0, 5);
        fnd[i]     = 1'($urandom);
        if (done_at[i] > last) last = done_at[i];
      end
      win = model_winner();
      load_work();
      n_total++; if (bus.prev_h !== exp_prev_h) $display("FAIL rand_prev_h it=%0d got=%h exp=%h", it, bus.prev_h, exp_prev_h); else n_pass++;
      n_total++; if (bus.input_m !== exp_input_m) $display("FAIL rand_input_m it=%0d got=%h exp=%h", it, bus.input_m, exp_input_m); else n_pass++;
      n_total++; if (bus.prev_blk !== exp_prev_blk) $display("FAIL rand_prev_blk it=%0d got=%h exp=%h", it, bus.prev_blk, exp_prev_blk); else n_pass++;
      for (int c = 0; c <= last; c++) begin
        b  = 8'($urandom);
        if (b == 8'hA7) b = 8'h00;
        rv = 1'($urandom);
        run_cycle(c, rv, b, 1'b1);
        n_total++;
        if (bus.busy !== (c < last)) $display("FAIL rand_busy it=%0d cyc=%0d got=%b exp=%b", it, c, bus.busy, c < last);
        else n_pass++;
        n_total++;
        if (bus.tx_data !== ((c < last) ? 8'hA1 : ((win >= 0) ? 8'hA6 : 8'hA5)))
          $display("FAIL rand_tx it=%0d cyc=%0d got=%h exp=%h", it, c, bus.tx_data,
                   (c < last) ? 8'hA1 : ((win >= 0) ? 8'hA6 : 8'hA5));
        else n_pass++;
      end
      if (win >= 0) begin
        build_readout(win);
        send_byte(8'hA4);
        for (int k = 0; k < exp_q.size(); k++) begin
          if (k > 0) send_byte(8'($urandom));
          n_total++;
          if (bus.tx_data !== exp_q[k]) $display("FAIL rand_stream it=%0d byte=%0d got=%h exp=%h", it, k, bus.tx_data, exp_q[k]);
          else n_pass++;
        end
      end else begin
        send_byte(8'hA4);
        n_total++; if (bus.tx_data !== 8'hA5) $display("FAIL rand_get_ignored it=%0d got=%h exp=a5", it, bus.tx_data); else n_pass++;
      end
      send_byte(8'hA3);
      n_total++; if (bus.tx_data !== 8'h40) $display("FAIL rand_status it=%0d got=%h exp=40", it, bus.tx_data); else n_pass++;
    end
  endtask

  initial begin
    bus.rx_valid = 1'b0; bus.rx_data = 8'h00;
    bus.core_done = '0; bus.core_found = '0;
    bus.core_nonce = '0; bus.core_hash = '0;
    test_reset();
    test_load();
    test_find();
    test_no_find();
    test_abort();
    test_status_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
